unified_mem_arbiter: RTL

Shares one single-port unified memory between the CPU instruction-fetch port and the CPU data (load/store) port.
It grants the memory to one requester at a time and returns read data with a one-cycle acknowledge pulse.
It raises a pipeline stall request while any port is waiting for service.
It sits between the openmips core and the unified RAM, replacing the separate instruction ROM and data RAM paths.

---
 rtl/unified_mem_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port unified RAM between the instruction-fetch and load/store ports.
// Data wins in IDLE; after each access the other waiting port is granted directly.
//
// state  | meaning
// IDLE   | no access in flight, sample both requests (data first)
// ACCESS | RAM driven from the registered request, read data captured at the edge
// RESP   | owner's ack pulses; the other port is granted directly if it is waiting
module unified_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inst_ce_i,
   input  logic [ADDR_W-1:0]   inst_addr_i,
   output logic [DATA_W-1:0]   inst_o,
   output logic                inst_ack_o,
   input  logic                data_ce_i,
   input  logic                data_we_i,
   input  logic [ADDR_W-1:0]   data_addr_i,
   input  logic [DATA_W/8-1:0] data_sel_i,
   input  logic [DATA_W-1:0]   data_wdata_i,
   output logic [DATA_W-1:0]   data_rdata_o,
   output logic                data_ack_o,
   output logic                stallreq_o,
   output logic                ram_ce_o,
   output logic                ram_we_o,
   output logic [ADDR_W-1:0]   ram_addr_o,
   output logic [DATA_W/8-1:0] ram_sel_o,
   output logic [DATA_W-1:0]   ram_data_o,
   input  logic [DATA_W-1:0]   ram_data_i
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   typedef enum logic {OWN_INST, OWN_DATA} owner_t;

   state_t state_q, state_d;
   owner_t owner_q, owner_d;
   logic   load_req;

   logic                req_we_q;
   logic [ADDR_W-1:0]   req_addr_q;
   logic [DATA_W/8-1:0] req_sel_q;
   logic [DATA_W-1:0]   req_wdata_q;
   logic [DATA_W-1:0]   inst_q;
   logic [DATA_W-1:0]   rdata_q;

   logic in_access;
   logic in_resp;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      load_req = 1'b0;
      case (state_q)
         IDLE: begin
            if (data_ce_i) begin
               owner_d  = OWN_DATA;
               state_d  = ACCESS;
               load_req = 1'b1;
            end else if (inst_ce_i) begin
               owner_d  = OWN_INST;
               state_d  = ACCESS;
               load_req = 1'b1;
            end
         end
         ACCESS: state_d = RESP;
         RESP: begin
            // Only the non-acked port is considered, which forces alternation.
            if ((owner_q == OWN_INST) ? data_ce_i : inst_ce_i) begin
               owner_d  = (owner_q == OWN_INST) ? OWN_DATA : OWN_INST;
               state_d  = ACCESS;
               load_req = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_INST;
         req_we_q    <= 1'b0;
         req_addr_q  <= '0;
         req_sel_q   <= '0;
         req_wdata_q <= '0;
         inst_q      <= '0;
         rdata_q     <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         if (load_req) begin
            if (owner_d == OWN_DATA) begin
               req_we_q    <= data_we_i;
               req_addr_q  <= data_addr_i;
               req_sel_q   <= data_sel_i;
               req_wdata_q <= data_wdata_i;
            end else begin
               req_we_q    <= 1'b0;
               req_addr_q  <= inst_addr_i;
               req_sel_q   <= '1;
               req_wdata_q <= '0;
            end
         end
         if (state_q == ACCESS) begin
            if (owner_q == OWN_INST) inst_q <= ram_data_i;
            else if (!req_we_q)      rdata_q <= ram_data_i;
         end
      end
   end

   // Gating with ~rst keeps a store caught by reset from committing.
   assign in_access = (state_q == ACCESS) && !rst;
   assign in_resp   = (state_q == RESP) && !rst;

   assign ram_ce_o   = in_access;
   assign ram_we_o   = in_access && req_we_q;
   assign ram_addr_o = in_access ? req_addr_q  : '0;
   assign ram_sel_o  = in_access ? req_sel_q   : '0;
   assign ram_data_o = in_access ? req_wdata_q : '0;

   assign inst_ack_o   = in_resp && (owner_q == OWN_INST);
   assign data_ack_o   = in_resp && (owner_q == OWN_DATA);
   assign inst_o       = inst_q;
   assign data_rdata_o = rdata_q;
   assign stallreq_o   = (inst_ce_i && !inst_ack_o) || (data_ce_i && !data_ack_o);

endmodule
